riscv_hazard_ctrl: RTL and testbench
====================================

# riscv_hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the decode stage and tracks the destination registers of instructions in flight in EX, MEM and WB. From that tracking it drives the operand-forwarding selects for the decode operands, raises the load-use stall, flushes IF/ID after a taken branch or jump, and freezes the whole pipe while data memory is busy.

## Interface
- `FLUSH_CYCLES`, 2: cycles `flush_id_o` stays asserted after a taken branch, including the branch cycle; legal range 1..3.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid_i` in 1: ID holds a valid instruction.
- `id_rs1_idx_i` in 5: rs1 index of the instruction in ID.
- `id_rs2_idx_i` in 5: rs2 index of the instruction in ID.
- `id_rs_re_i` in 1: the ID instruction reads rs1/rs2.
- `id_rd_idx_i` in 5: rd index of the ID instruction.
- `id_rd_we_i` in 1: the ID instruction writes rd.
- `id_data_re_i` in 1: the ID instruction is a load.
- `ex_br_taken_i` in 1: EX resolved a taken branch/jump this cycle.
- `mem_busy_i` in 1: data memory not ready; pipe must hold.
- `stall_if_o` out 1: hold PC and the IF/ID register.
- `stall_id_o` out 1: hold the ID instruction.
- `bubble_ex_o` out 1: load a NOP into ID/EX (rd_we=0, data_we=0, br=0).
- `flush_id_o` out 1: invalidate the IF/ID register.
- `freeze_o` out 1: hold every pipeline register.
- `fwd_a_sel_o` out 2: rs1 operand source (00 regfile, 01 EX ALU result, 10 MEM result, 11 WB result).
- `fwd_b_sel_o` out 2: rs2 operand source, same encoding as `fwd_a_sel_o`.

## Operation
- Tracker: three entries, EX/MEM/WB, each holding {valid, rd, we, re}.
  - On every non-frozen edge: WB<=MEM, MEM<=EX, EX<=issue ? {1, id_rd_idx_i, id_rd_we_i, id_data_re_i} : 0.
  - `issue` = id_valid_i & !load_use & !flush_active.
- Hit rules:
  - hit_X(rs) = X.valid & X.we & (X.rd == rs) & (rs != 0) & id_rs_re_i.
  - Priority is EX > MEM > WB, so the youngest producer wins.
- Load-use:
  - load_use = id_valid_i & (hit_EX(rs1)|hit_EX(rs2)) & EX.re.
  - Effect: stall_if_o = stall_id_o = bubble_ex_o = 1 for one cycle.
  - Next cycle the load sits in MEM and selects 10.
- Forwarding sel = 01/10/11 on hit_EX/hit_MEM/hit_WB, else 00.
  - A selection pointing at an EX load is never consumed, because load_use blocks issue.
- FSM states:
  - RUN: normal.
  - RUN -> FLUSH on ex_br_taken_i & !mem_busy_i. Counter is loaded with FLUSH_CYCLES-1.
  - FLUSH: flush_id_o=1, bubble_ex_o=1. Decrement the counter each non-frozen cycle; return to RUN at 0.
  - Any -> FREEZE when mem_busy_i=1. The prior state and counter are saved.
  - FREEZE: freeze_o=1. All other outputs are 0 except the fwd selects, which stay valid. Tracker and counter hold. Return to the saved state when mem_busy_i=0.
- flush_active = ex_br_taken_i | (state == FLUSH).
- On the branch cycle itself (still RUN), flush_id_o = bubble_ex_o = 1 combinationally.
- Priority: mem_busy_i > ex_br_taken_i > load_use.
  - A taken branch suppresses a simultaneous load-use stall (the stalled instruction is wrong-path).
  - ex_br_taken_i seen while mem_busy_i=1 is ignored; EX holds it and it acts on the first unfrozen cycle.
- A taken branch arriving while already in FLUSH reloads the counter.

## Timing
- All control outputs are combinational from the tracker, state and inputs. No input-to-register latency beyond one edge.
- Tracker, state and counter update on the rising clk edge.
- Reset:
  - Asserting rst_n=0 immediately clears the tracker valid bits, the state (RUN) and the counter, mid-operation included.
  - Outputs are all 0, fwd selects 00.
  - The first cycle after release produces no hits.
- Load-use costs exactly 1 bubble. A taken branch costs FLUSH_CYCLES bubbles plus freeze cycles.
- x0 is never a hazard, regardless of we.

## Structure
- Shared package `riscv_define.v`:
  - FWD_REG/FWD_EX/FWD_MEM/FWD_WB encodings.
  - FSM state encodings RUN/FLUSH/FREEZE.
  - Existing `RegAddrBus`.
- Sub-module `riscv_fwd_sel`:
  - Combinational; takes one source index and the three tracker entries, returns a 2-bit select and an ex_load_hit flag.
  - Instantiated twice (rs1, rs2).

## Test plan
- Forward chain: `add x5,x1,x2` then `sub x6,x5,x3` -> sub in ID sees fwd_a_sel_o=01, no stall. The following `or x7,x5,x5` sees fwd_a=fwd_b=10.
- Load-use: `lw x8,0(x1)` then `add x9,x8,x0` -> one cycle of stall_if_o=stall_id_o=bubble_ex_o=1, then fwd_a_sel_o=10, no second stall.
- x0: `addi x0,x0,5` then `add x1,x0,x0` -> fwd selects 00, no stall.
- Taken branch with FLUSH_CYCLES=2: ex_br_taken_i for one cycle -> flush_id_o=1 for 2 cycles; the tracker EX entry is invalid for those 2 issues.
- Freeze: mem_busy_i=1 for 3 cycles during FLUSH with counter=1 -> freeze_o=1 for 3 cycles, then 1 further flush cycle, then RUN.
- Simultaneous events:
  - ex_br_taken_i together with a load-use hit -> no stall, flush asserted.
  - rst_n pulse low mid-FLUSH -> all outputs 0 immediately, RUN after release.

Source files
------------

// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package riscv_hazard_ctrl_pkg;

   typedef logic [4:0] reg_addr_t;

   // Operand source encodings for the decode-stage forwarding muxes.
   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_e;

   // Controller states; FREEZE remembers which of RUN/FLUSH to resume.
   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_FLUSH  = 2'b01,
      ST_FREEZE = 2'b10
   } hz_state_e;

   // One in-flight instruction as seen by the hazard tracker.
   typedef struct packed {
      logic      valid;
      reg_addr_t rd;
      logic      we;
      logic      re;
   } trk_entry_t;

   localparam trk_entry_t TRK_EMPTY = '0;

   // True when entry e produces the register that the ID instruction reads.
   function automatic logic trk_hit(trk_entry_t e, reg_addr_t rs, logic rs_re);
      return e.valid & e.we & (e.rd == rs) & (rs != 5'd0) & rs_re;
   endfunction

endpackage

// File: rtl/riscv_hazard_ctrl_if.sv
// Decode-side control bundle between the hazard controller and the pipeline.
interface riscv_hazard_ctrl_if;

   logic       id_valid_i;
   logic [4:0] id_rs1_idx_i;
   logic [4:0] id_rs2_idx_i;
   logic       id_rs_re_i;
   logic [4:0] id_rd_idx_i;
   logic       id_rd_we_i;
   logic       id_data_re_i;
   logic       ex_br_taken_i;
   logic       mem_busy_i;
   logic       stall_if_o;
   logic       stall_id_o;
   logic       bubble_ex_o;
   logic       flush_id_o;
   logic       freeze_o;
   logic [1:0] fwd_a_sel_o;
   logic [1:0] fwd_b_sel_o;

   // Pipeline side: drives decode information, consumes hazard controls.
   modport master (
      output id_valid_i, id_rs1_idx_i, id_rs2_idx_i, id_rs_re_i,
      output id_rd_idx_i, id_rd_we_i, id_data_re_i, ex_br_taken_i, mem_busy_i,
      input  stall_if_o, stall_id_o, bubble_ex_o, flush_id_o, freeze_o,
      input  fwd_a_sel_o, fwd_b_sel_o
   );

   // Hazard controller side.
   modport slave (
      input  id_valid_i, id_rs1_idx_i, id_rs2_idx_i, id_rs_re_i,
      input  id_rd_idx_i, id_rd_we_i, id_data_re_i, ex_br_taken_i, mem_busy_i,
      output stall_if_o, stall_id_o, bubble_ex_o, flush_id_o, freeze_o,
      output fwd_a_sel_o, fwd_b_sel_o
   );

endinterface

// File: rtl/riscv_hazard_ctrl_fwd_sel.sv
// Forwarding select for one decode operand: youngest matching producer wins.
module riscv_fwd_sel
   import riscv_hazard_ctrl_pkg::*;
(
   input  reg_addr_t  i_rs_idx,
   input  logic       i_rs_re,
   input  trk_entry_t i_ex,
   input  trk_entry_t i_mem,
   input  trk_entry_t i_wb,
   output fwd_sel_e   o_sel,
   output logic       o_ex_load_hit
);

   logic w_hit_ex;
   logic w_hit_mem;
   logic w_hit_wb;

   // Priority EX > MEM > WB; flag an EX hit on a load for the load-use stall.
   always_comb begin
      w_hit_ex      = trk_hit(i_ex,  i_rs_idx, i_rs_re);
      w_hit_mem     = trk_hit(i_mem, i_rs_idx, i_rs_re);
      w_hit_wb      = trk_hit(i_wb,  i_rs_idx, i_rs_re);
      o_ex_load_hit = w_hit_ex & i_ex.re;
      if (w_hit_ex)       o_sel = FWD_EX;
      else if (w_hit_mem) o_sel = FWD_MEM;
      else if (w_hit_wb)  o_sel = FWD_WB;
      else                o_sel = FWD_REG;
   end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Pipeline hazard controller: tracks rd of EX/MEM/WB, drives forwarding,
// load-use stall, post-branch IF/ID flush and memory-busy freeze.
module riscv_hazard_ctrl
   import riscv_hazard_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
)(
   input  logic                 clk,
   input  logic                 rst_n,
   riscv_hazard_ctrl_if.slave   hz
);

   localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

   trk_entry_t r_ex, r_mem, r_wb;
   hz_state_e  r_state, r_saved_state;
   logic [1:0] r_cnt;

   hz_state_e  w_next_state, w_next_saved, w_eff_state;
   logic [1:0] w_next_cnt;
   fwd_sel_e   w_sel_a, w_sel_b;
   logic       w_ex_ld_a, w_ex_ld_b;
   logic       w_load_use, w_flush_active, w_issue;

   riscv_fwd_sel u_fwd_a (
      .i_rs_idx      (hz.id_rs1_idx_i),
      .i_rs_re       (hz.id_rs_re_i),
      .i_ex          (r_ex),
      .i_mem         (r_mem),
      .i_wb          (r_wb),
      .o_sel         (w_sel_a),
      .o_ex_load_hit (w_ex_ld_a)
   );

   riscv_fwd_sel u_fwd_b (
      .i_rs_idx      (hz.id_rs2_idx_i),
      .i_rs_re       (hz.id_rs_re_i),
      .i_ex          (r_ex),
      .i_mem         (r_mem),
      .i_wb          (r_wb),
      .o_sel         (w_sel_b),
      .o_ex_load_hit (w_ex_ld_b)
   );

   // Hazard qualifiers; leaving FREEZE behaves as the saved state in the same
   // cycle so a freeze costs exactly the busy cycles.
   always_comb begin
      w_eff_state    = (r_state == ST_FREEZE) ? r_saved_state : r_state;
      w_load_use     = hz.id_valid_i & (w_ex_ld_a | w_ex_ld_b);
      w_flush_active = hz.ex_br_taken_i | (w_eff_state == ST_FLUSH);
      w_issue        = hz.id_valid_i & ~w_load_use & ~w_flush_active;
   end

   // Tracker shift: WB<=MEM<=EX<=ID, held while memory is busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex  <= TRK_EMPTY;
         r_mem <= TRK_EMPTY;
         r_wb  <= TRK_EMPTY;
      end else if (!hz.mem_busy_i) begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         r_ex  <= w_issue ? '{valid: 1'b1, rd: hz.id_rd_idx_i,
                              we: hz.id_rd_we_i, re: hz.id_data_re_i}
                          : TRK_EMPTY;
      end
   end

   // FSM state, saved state and flush counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_RUN;
         r_saved_state <= ST_RUN;
         r_cnt         <= '0;
      end else begin
         r_state       <= w_next_state;
         r_saved_state <= w_next_saved;
         r_cnt         <= w_next_cnt;
      end
   end

   // Next state: busy > taken branch > flush countdown.
   always_comb begin
      w_next_state = r_state;
      w_next_saved = r_saved_state;
      w_next_cnt   = r_cnt;
      if (hz.mem_busy_i) begin
         w_next_state = ST_FREEZE;
         w_next_saved = w_eff_state;
      end else if (hz.ex_br_taken_i) begin
         w_next_cnt   = CNT_LOAD;
         w_next_state = (CNT_LOAD != 2'd0) ? ST_FLUSH : ST_RUN;
      end else if (w_eff_state == ST_FLUSH) begin
         w_next_cnt   = r_cnt - 2'd1;
         w_next_state = (r_cnt <= 2'd1) ? ST_RUN : ST_FLUSH;
      end else begin
         w_next_state = ST_RUN;
      end
   end

   // Control outputs; forced low while reset is asserted.
   always_comb begin
      hz.stall_if_o  = 1'b0;
      hz.stall_id_o  = 1'b0;
      hz.bubble_ex_o = 1'b0;
      hz.flush_id_o  = 1'b0;
      hz.freeze_o    = 1'b0;
      hz.fwd_a_sel_o = rst_n ? w_sel_a : FWD_REG;
      hz.fwd_b_sel_o = rst_n ? w_sel_b : FWD_REG;
      if (rst_n) begin
         if (hz.mem_busy_i) begin
            hz.freeze_o = 1'b1;
         end else if (w_flush_active) begin
            hz.flush_id_o  = 1'b1;
            hz.bubble_ex_o = 1'b1;
         end else if (w_load_use) begin
            hz.stall_if_o  = 1'b1;
            hz.stall_id_o  = 1'b1;
            hz.bubble_ex_o = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl: directed scenarios plus a
// randomized run against an in-flight-list reference model.
module tb_riscv_hazard_ctrl;

   localparam int unsigned FC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [8:0] exp_v;

   riscv_hazard_ctrl_if hz ();

   riscv_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   // Reference model: youngest-first list of in-flight producers.
   bit         m_v [3];
   logic [4:0] m_rd[3];
   bit         m_we[3];
   bit         m_re[3];
   int         m_fl;

   function automatic logic [8:0] obs();
      return {hz.stall_if_o, hz.stall_id_o, hz.bubble_ex_o, hz.flush_id_o,
              hz.freeze_o, hz.fwd_a_sel_o, hz.fwd_b_sel_o};
   endfunction

   function automatic logic [8:0] pk(bit si, bit sd, bit bx, bit fl, bit fz,
                                     logic [1:0] a, logic [1:0] b);
      return {si, sd, bx, fl, fz, a, b};
   endfunction

   function automatic logic [1:0] msel(logic [4:0] rs, bit rre);
      for (int i = 0; i < 3; i++)
         if (m_v[i] && m_we[i] && m_rd[i] == rs && rs != 5'd0 && rre)
            return 2'(i + 1);
      return 2'd0;
   endfunction

   task automatic drive(input bit v, input logic [4:0] r1, input logic [4:0] r2,
                        input bit rre, input logic [4:0] rd, input bit we,
                        input bit re, input bit br, input bit busy);
      hz.id_valid_i    = v;
      hz.id_rs1_idx_i  = r1;
      hz.id_rs2_idx_i  = r2;
      hz.id_rs_re_i    = rre;
      hz.id_rd_idx_i   = rd;
      hz.id_rd_we_i    = we;
      hz.id_data_re_i  = re;
      hz.ex_br_taken_i = br;
      hz.mem_busy_i    = busy;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1, 5'd5, 5'd6, 1, 5'd7, 1, 1, 1, 1);
      @(negedge clk);
      total++;
      if (obs() !== 9'd0) begin
         bad++; $display("FAIL reset_outputs got=%b exp=%b", obs(), 9'd0);
      end
      next_cycle();
      rst_n = 1'b1;
      drive(1, 5'd5, 5'd7, 1, 5'd7, 1, 0, 0, 0);
      @(negedge clk);
      total++;
      if (obs() !== 9'd0) begin
         bad++; $display("FAIL reset_first_cycle got=%b exp=%b", obs(), 9'd0);
      end
      next_cycle();
   endtask

   task automatic test_forward_chain();
      do_reset();
      drive(1, 5'd1, 5'd2, 1, 5'd5, 1, 0, 0, 0);             // add x5,x1,x2
      next_cycle();
      drive(1, 5'd5, 5'd3, 1, 5'd6, 1, 0, 0, 0);             // sub x6,x5,x3
      exp_v = pk(0, 0, 0, 0, 0, 2'b01, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL fwd_ex got=%b exp=%b", obs(), exp_v); end
      next_cycle();
      drive(1, 5'd5, 5'd5, 1, 5'd7, 1, 0, 0, 0);             // or x7,x5,x5
      exp_v = pk(0, 0, 0, 0, 0, 2'b10, 2'b10);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL fwd_mem got=%b exp=%b", obs(), exp_v); end
      next_cycle();
      drive(1, 5'd5, 5'd6, 1, 5'd8, 1, 0, 0, 0);             // and x8,x5,x6
      exp_v = pk(0, 0, 0, 0, 0, 2'b11, 2'b10);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL fwd_wb got=%b exp=%b", obs(), exp_v); end
      next_cycle();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 5'd1, 5'd0, 1, 5'd8, 1, 1, 0, 0);             // lw x8,0(x1)
      next_cycle();
      drive(1, 5'd8, 5'd0, 1, 5'd9, 1, 0, 0, 0);             // add x9,x8,x0
      exp_v = pk(1, 1, 1, 0, 0, 2'b01, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL load_use_stall got=%b exp=%b", obs(), exp_v); end
      next_cycle();
      exp_v = pk(0, 0, 0, 0, 0, 2'b10, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL load_use_release got=%b exp=%b", obs(), exp_v); end
      next_cycle();
   endtask

   task automatic test_x0_and_no_read();
      do_reset();
      drive(1, 5'd0, 5'd0, 1, 5'd0, 1, 1, 0, 0);             // load into x0
      next_cycle();
      drive(1, 5'd0, 5'd0, 1, 5'd1, 1, 0, 0, 0);             // add x1,x0,x0
      @(negedge clk); total++;
      if (obs() !== 9'd0) begin bad++; $display("FAIL x0_no_hazard got=%b exp=%b", obs(), 9'd0); end
      next_cycle();
      drive(1, 5'd1, 5'd1, 0, 5'd2, 1, 0, 0, 0);             // x1 in EX, rs not read
      @(negedge clk); total++;
      if (obs() !== 9'd0) begin bad++; $display("FAIL no_read_no_hit got=%b exp=%b", obs(), 9'd0); end
      next_cycle();
   endtask

   task automatic test_branch_flush();
      do_reset();
      drive(1, 5'd1, 5'd2, 1, 5'd5, 1, 0, 0, 0);             // add x5
      next_cycle();
      drive(1, 5'd5, 5'd0, 1, 5'd6, 1, 0, 1, 0);             // branch taken
      exp_v = pk(0, 0, 1, 1, 0, 2'b01, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL branch_cycle got=%b exp=%b", obs(), exp_v); end
      next_cycle();
      drive(1, 5'd5, 5'd0, 1, 5'd7, 1, 0, 0, 0);
      exp_v = pk(0, 0, 1, 1, 0, 2'b10, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL flush_second got=%b exp=%b", obs(), exp_v); end
      next_cycle();
      drive(1, 5'd5, 5'd5, 1, 5'd10, 1, 0, 0, 0);
      exp_v = pk(0, 0, 0, 0, 0, 2'b11, 2'b11);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL flush_end_no_issue got=%b exp=%b", obs(), exp_v); end
      next_cycle();
   endtask

   task automatic test_freeze_in_flush();
      do_reset();
      drive(1, 5'd1, 5'd2, 1, 5'd5, 1, 0, 0, 0);             // add x5
      next_cycle();
      drive(1, 5'd5, 5'd0, 1, 5'd6, 1, 0, 1, 0);             // branch taken
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         drive(1, 5'd5, 5'd0, 1, 5'd6, 1, 0, 0, 1);
         exp_v = pk(0, 0, 0, 0, 1, 2'b10, 2'b00);
         @(negedge clk); total++;
         if (obs() !== exp_v) begin bad++; $display("FAIL freeze_c%0d got=%b exp=%b", c, obs(), exp_v); end
         next_cycle();
      end
      drive(1, 5'd5, 5'd0, 1, 5'd6, 1, 0, 0, 0);
      exp_v = pk(0, 0, 1, 1, 0, 2'b10, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL freeze_resume_flush got=%b exp=%b", obs(), exp_v); end
      next_cycle();
      exp_v = pk(0, 0, 0, 0, 0, 2'b11, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL freeze_back_run got=%b exp=%b", obs(), exp_v); end
      next_cycle();
   endtask

   task automatic test_branch_vs_load_use();
      do_reset();
      drive(1, 5'd1, 5'd0, 1, 5'd8, 1, 1, 0, 0);             // lw x8
      next_cycle();
      drive(1, 5'd8, 5'd0, 1, 5'd9, 1, 0, 1, 0);             // use + branch
      exp_v = pk(0, 0, 1, 1, 0, 2'b01, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL br_beats_load_use got=%b exp=%b", obs(), exp_v); end
      next_cycle();
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0);
      next_cycle();
      drive(1, 5'd3, 5'd4, 1, 5'd5, 1, 0, 0, 0);
      exp_v = pk(0, 0, 1, 1, 0, 2'b00, 2'b00);
      @(negedge clk); total++;
      if (obs() !== exp_v) begin bad++; $display("FAIL pre_reset_flush got=%b exp=%b", obs(), exp_v); end
      rst_n = 1'b0;
      drive(1, 5'd3, 5'd4, 1, 5'd5, 1, 0, 1, 0);
      #1; total++;
      if (obs() !== 9'd0) begin bad++; $display("FAIL reset_mid_flush got=%b exp=%b", obs(), 9'd0); end
      next_cycle();
      rst_n = 1'b1;
      drive(1, 5'd3, 5'd4, 1, 5'd5, 1, 0, 0, 0);
      @(negedge clk); total++;
      if (obs() !== 9'd0) begin bad++; $display("FAIL after_reset_run got=%b exp=%b", obs(), 9'd0); end
      next_cycle();
   endtask

   task automatic test_random();
      bit v, rre, we, re, br, busy, fl, lu, st, issue;
      logic [4:0] r1, r2, rd;
      logic [1:0] a, b;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         m_v[i] = 0; m_rd[i] = '0; m_we[i] = 0; m_re[i] = 0;
      end
      m_fl = 0;
      for (int n = 0; n < 600; n++) begin
         v    = ($urandom_range(9) < 8);
         r1   = 5'($urandom_range(7));
         r2   = 5'($urandom_range(7));
         rre  = ($urandom_range(9) < 9);
         rd   = 5'($urandom_range(7));
         we   = ($urandom_range(9) < 7);
         re   = ($urandom_range(9) < 3);
         br   = ($urandom_range(9) < 1);
         busy = ($urandom_range(19) < 3);
         drive(v, r1, r2, rre, rd, we, re, br, busy);
         a  = msel(r1, rre);
         b  = msel(r2, rre);
         fl = br || (m_fl > 0);
         lu = v && m_v[0] && m_re[0] && (a == 2'd1 || b == 2'd1);
         st = lu && !fl;
         if (busy) exp_v = pk(0, 0, 0, 0, 1, a, b);
         else      exp_v = pk(st, st, fl || st, fl, 0, a, b);
         @(negedge clk); total++;
         if (obs() !== exp_v) begin
            bad++; $display("FAIL random_n%0d got=%b exp=%b", n, obs(), exp_v);
         end
         if (!busy) begin
            issue = v && !lu && !fl;
            for (int i = 2; i > 0; i--) begin
               m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1];
               m_we[i] = m_we[i-1]; m_re[i] = m_re[i-1];
            end
            m_v[0] = issue; m_rd[0] = issue ? rd : 5'd0;
            m_we[0] = issue && we; m_re[0] = issue && re;
            if (br)            m_fl = int'(FC) - 1;
            else if (m_fl > 0) m_fl = m_fl - 1;
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_forward_chain();
      test_load_use();
      test_x0_and_no_read();
      test_branch_flush();
      test_freeze_in_flush();
      test_branch_vs_load_use();
      test_reset_mid_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
